serial_mag_comp: RTL and testbench
==================================

Name: serial_mag_comp

Overview:
Sequential magnitude comparator for WIDTH-bit unsigned operands. It walks the operands MSB-first, one 2-bit digit pair per clock, using the team's 2-bit LG/EQ/SM comparison as its per-digit step. It terminates early on the first unequal digit pair. It sits downstream of operand registers and upstream of control logic that needs a registered greater/equal/smaller verdict with a done strobe.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; N = WIDTH/2 digit pairs.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
START  input  1  request a comparison; sampled only in IDLE
A  input  WIDTH  operand X, captured on accepted START
B  input  WIDTH  operand Y, captured on accepted START
BUSY  output  1  high while a comparison is in progress
DONE  output  1  one-cycle pulse when the result flags become valid
LG  output  1  A > B, registered
EQ  output  1  A == B, registered
SM  output  1  A < B, registered

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST.
- Reset (RST high at a clock edge):
  - State goes to IDLE.
  - BUSY=0, DONE=0, LG=0, EQ=0, SM=0.
  - Digit index and shift registers are cleared.
  - RST has priority over every other input.
- States: IDLE, RUN.
- IDLE:
  - When START=1 at edge t, A and B are copied into the internal shift registers SA and SB, and the digit index k is set to 0.
  - LG, EQ and SM are cleared to 0, BUSY goes to 1 and the state moves to RUN.
  - When START=0, nothing changes and the flags hold their last result.
- RUN, evaluated at every edge:
  - Take digit pair x=SA[WIDTH-1:WIDTH-2] and y=SB[WIDTH-1:WIDTH-2].
  - If x>y: LG=1, DONE=1, BUSY=0, state goes to IDLE.
  - If x<y: SM=1, DONE=1, BUSY=0, state goes to IDLE.
  - If x==y and k==N-1: EQ=1, DONE=1, BUSY=0, state goes to IDLE.
  - If x==y and k<N-1: SA and SB shift left by 2, k increments, state stays in RUN.
- Latency:
  - If the first unequal pair is at index j, DONE and the result are visible after edge t+1+j.
  - An equal result appears after edge t+N. Minimum latency is 1 cycle; maximum is N cycles.
- DONE is high for exactly one cycle, then deasserts at the next edge.
- LG, EQ and SM are held after DONE until the next accepted START or RST.
- After a completed comparison, exactly one of LG, EQ and SM is 1. All three are 0 while BUSY and after reset.
- START while BUSY is ignored: no restart and no queuing.
- START in the same cycle DONE is high is accepted, because the state is already IDLE. At that edge the flags clear, DONE drops and BUSY rises.
- A and B are don't-care after capture; changing them during RUN has no effect.
- RST during RUN aborts the comparison: no DONE pulse and flags at 0.
- The index counter is sized clog2(N), minimum 1 bit, and never wraps, because RUN always exits at k=N-1.

Test Plan:
- WIDTH=8; A=0xB4, B=0xB4; START for 1 cycle -> BUSY high for 4 cycles; DONE pulses 4 cycles after the START edge with EQ=1, LG=0, SM=0; flags hold for 10 idle cycles.
- A=0x80, B=0x7F -> first pair 10 vs 01; DONE 1 cycle after START with LG=1; BUSY high for exactly 1 cycle.
- A=0x12, B=0x13 -> pairs 00,01,00 are equal, then 10 vs 11; DONE 4 cycles after START with SM=1.
- Accept A=0x40, B=0x00; next cycle drive START=1 with A=0x00, B=0xFF, and change A each cycle -> START is ignored; DONE after 1 cycle with LG=1; exactly one DONE pulse.
- Start A=0x05, B=0x05; assert RST for 1 cycle at the second RUN cycle -> next cycle BUSY=0, DONE=0, flags 0; no DONE follows in the next 8 cycles.
- Back-to-back: hold START=1 through the DONE cycle of A=0xFF, B=0x00, then A=0x00, B=0xFF -> first DONE with LG=1; next cycle LG=0 and BUSY=1; second DONE 1 cycle later with SM=1.

Source files
------------

// File: rtl/serial_mag_comp_if.sv
// serial_mag_comp_if: operand/request and verdict signals of the serial magnitude comparator
interface serial_mag_comp_if #(parameter int WIDTH = 8);
  logic START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic BUSY;
  logic DONE;
  logic LG;
  logic EQ;
  logic SM;
  modport master (output START, A, B, input BUSY, DONE, LG, EQ, SM);
  modport slave (input START, A, B, output BUSY, DONE, LG, EQ, SM);
endinterface

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: MSB-first 2-bit-digit magnitude comparator with early exit and DONE strobe
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input logic CLK,
  input logic RST,
  serial_mag_comp_if.slave bus
);
  localparam int N = WIDTH / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [KW-1:0] k_q, k_d;
  logic busy_q, busy_d, done_q, done_d;
  logic lg_q, lg_d, eq_q, eq_d, sm_q, sm_d;
  logic [2:0] r;
  logic fin;
  function automatic logic [2:0] cmp2(input logic [1:0] x, input logic [1:0] y);
    return {x > y, x == y, x < y};
  endfunction
  assign r = cmp2(sa_q[WIDTH-1 -: 2], sb_q[WIDTH-1 -: 2]);
  // an equal final digit pair also terminates, with r already reading EQ
  assign fin = r[2] | r[0] | (k_q == KW'(N - 1));
  always_comb begin
    state_d = state_q;
    sa_d = sa_q;
    sb_d = sb_q;
    k_d = k_q;
    busy_d = busy_q;
    done_d = 1'b0;
    {lg_d, eq_d, sm_d} = {lg_q, eq_q, sm_q};
    if (state_q == IDLE) begin
      if (bus.START) begin
        sa_d = bus.A;
        sb_d = bus.B;
        k_d = '0;
        {lg_d, eq_d, sm_d} = 3'b000;
        busy_d = 1'b1;
        state_d = RUN;
      end
    end else if (fin) begin
      {lg_d, eq_d, sm_d} = r;
      done_d = 1'b1;
      busy_d = 1'b0;
      state_d = IDLE;
    end else begin
      sa_d = sa_q << 2;
      sb_d = sb_q << 2;
      k_d = k_q + KW'(1);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      k_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lg_q <= 1'b0;
      eq_q <= 1'b0;
      sm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      k_q <= k_d;
      busy_q <= busy_d;
      done_q <= done_d;
      lg_q <= lg_d;
      eq_q <= eq_d;
      sm_q <= sm_d;
    end
  end
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.LG = lg_q;
  assign bus.EQ = eq_q;
  assign bus.SM = sm_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: directed vectors for serial_mag_comp at WIDTH=8
module tb_serial_mag_comp;
  logic CLK, RST;
  int total = 0, passed = 0;
  serial_mag_comp_if #(.WIDTH(8)) bus ();
  serial_mag_comp #(.WIDTH(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [2:0] flags();
    return {bus.LG, bus.EQ, bus.SM};
  endfunction
  task automatic go(input logic [7:0] a, input logic [7:0] b);
    bus.START = 1'b1;
    bus.A = a;
    bus.B = b;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("go_busy", {31'd0, bus.BUSY}, 1);
    chk("go_flags_clear", {29'd0, flags()}, 0);
  endtask
  task automatic wait_done(input string tag, input int lat, input logic [2:0] f);
    int n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      n = i;
      if (bus.DONE) break;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_flags"}, {29'd0, flags()}, {29'd0, f});
    chk({tag, "_busy_low"}, {31'd0, bus.BUSY}, 0);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, {31'd0, bus.DONE}, 0);
  endtask
  task automatic count_done(input string tag, input int cyc, input logic [2:0] f);
    int d = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge CLK);
      bus.A = bus.A + 8'h11;
      if (bus.DONE) d++;
    end
    chk({tag, "_no_done"}, d, 0);
    chk({tag, "_hold"}, {29'd0, flags()}, {29'd0, f});
  endtask
  initial begin
    RST = 1'b1;
    bus.START = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge CLK);
    chk("reset_state", {27'd0, bus.BUSY, bus.DONE, flags()}, 0);
    RST = 1'b0;
    go(8'hB4, 8'hB4);
    wait_done("eq_b4", 4, 3'b010);
    count_done("eq_hold", 10, 3'b010);
    go(8'h80, 8'h7F);
    wait_done("lg_80_7f", 1, 3'b100);
    go(8'h12, 8'h13);
    wait_done("sm_12_13", 4, 3'b001);
    go(8'h40, 8'h00);
    bus.START = 1'b1;
    bus.A = 8'h00;
    bus.B = 8'hFF;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("busy_ignore_done", {31'd0, bus.DONE}, 1);
    chk("busy_ignore_flags", {29'd0, flags()}, 3'b100);
    count_done("busy_ignore_after", 5, 3'b100);
    chk("busy_ignore_idle", {31'd0, bus.BUSY}, 0);
    go(8'h05, 8'h05);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_state", {27'd0, bus.BUSY, bus.DONE, flags()}, 0);
    count_done("abort_after", 8, 3'b000);
    bus.START = 1'b1;
    bus.A = 8'hFF;
    bus.B = 8'h00;
    @(negedge CLK);
    chk("b2b_busy1", {31'd0, bus.BUSY}, 1);
    bus.A = 8'h00;
    bus.B = 8'hFF;
    @(negedge CLK);
    chk("b2b_done1", {31'd0, bus.DONE}, 1);
    chk("b2b_flags1", {29'd0, flags()}, 3'b100);
    @(negedge CLK);
    bus.START = 1'b0;
    chk("b2b_restart", {29'd0, bus.BUSY, bus.DONE, bus.LG}, 3'b100);
    @(negedge CLK);
    chk("b2b_done2", {31'd0, bus.DONE}, 1);
    chk("b2b_flags2", {29'd0, flags()}, 3'b001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
